// File: rtl/sr_latch_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sr_latch_bank                                                            |
// | Clocked bank of WIDTH set/reset channels with load, change flags and a  |
// | saturating change counter.                                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sr_latch_bank #(
   parameter int               WIDTH       = 8,
   parameter int               MODE        = 0,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             c,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   input  logic             clr_cnt,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic [WIDTH-1:0] chg,
   output logic [WIDTH-1:0] sticky,
   output logic             conflict,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] chg_q, chg_d;
   logic [WIDTH-1:0] sticky_q, sticky_d;
   logic             conflict_q, conflict_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] set_only, rst_only, both, sr_q;
   logic             any_chg;

   always_comb begin
      set_only   = s & ~r;
      rst_only   = r & ~s;
      both       = s & r;
      sr_q       = (q_q | set_only) & ~rst_only;
      q_d        = q_q;
      conflict_d = 1'b0;

      // Exclusive set/reset are resolved first; simultaneous s&r follows MODE.
      if (ld) begin
         q_d = d;
      end else if (c) begin
         case (MODE)
            0:       q_d = sr_q & ~both;
            1:       q_d = sr_q | both;
            2:       q_d = sr_q ^ both;
            default: q_d = sr_q;
         endcase
         conflict_d = |both;
      end

      chg_d    = q_d ^ q_q;
      any_chg  = |chg_d;
      sticky_d = clr_cnt ? chg_d : (sticky_q | chg_d);

      cnt_d = cnt_q;
      if (clr_cnt) begin
         cnt_d = any_chg ? CNT_ONE : '0;
      end else if (any_chg && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q        <= RESET_VALUE;
         chg_q      <= '0;
         sticky_q   <= '0;
         conflict_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         q_q        <= q_d;
         chg_q      <= chg_d;
         sticky_q   <= sticky_d;
         conflict_q <= conflict_d;
         cnt_q      <= cnt_d;
      end
   end

   assign q        = q_q;
   assign qn       = ~q_q;
   assign chg      = chg_q;
   assign sticky   = sticky_q;
   assign conflict = conflict_q;
   assign cnt      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sr_latch_bank                                                         |
// | Five sr_latch_bank instances (MODE 0..3, plus a 2-bit counter one)       |
// | driven in parallel and checked against a per-bit behavioural model.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sr_latch_bank;

   localparam int         NI = 5;
   localparam int         MODES [NI] = '{0, 1, 2, 3, 2};
   localparam int         CMAX  [NI] = '{255, 255, 255, 255, 3};
   localparam logic [7:0] RV    [NI] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h5A};

   logic       clk = 1'b0;
   logic       rst, c, ld, clr_cnt;
   logic [7:0] s, r, d;

   logic [7:0] q_o [NI];
   logic [7:0] qn_o [NI];
   logic [7:0] chg_o [NI];
   logic [7:0] st_o [NI];
   logic       conf_o [NI];
   logic [7:0] cnt8 [4];
   logic [1:0] cnt2;
   logic [7:0] cnt_all [NI];

   logic [7:0] mq [NI];
   logic [7:0] mchg [NI];
   logic [7:0] mst [NI];
   logic       mconf [NI];
   int         mcnt [NI];

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 4; i++) cnt_all[i] = cnt8[i];
      cnt_all[4] = {6'b0, cnt2};
   end

   sr_latch_bank #(.WIDTH(8), .MODE(0), .RESET_VALUE(8'h00), .CNT_W(8)) u_m0 (
      .clk(clk), .rst(rst), .c(c), .s(s), .r(r), .ld(ld), .d(d), .clr_cnt(clr_cnt),
      .q(q_o[0]), .qn(qn_o[0]), .chg(chg_o[0]), .sticky(st_o[0]), .conflict(conf_o[0]), .cnt(cnt8[0]));
   sr_latch_bank #(.WIDTH(8), .MODE(1), .RESET_VALUE(8'h00), .CNT_W(8)) u_m1 (
      .clk(clk), .rst(rst), .c(c), .s(s), .r(r), .ld(ld), .d(d), .clr_cnt(clr_cnt),
      .q(q_o[1]), .qn(qn_o[1]), .chg(chg_o[1]), .sticky(st_o[1]), .conflict(conf_o[1]), .cnt(cnt8[1]));
   sr_latch_bank #(.WIDTH(8), .MODE(2), .RESET_VALUE(8'h00), .CNT_W(8)) u_m2 (
      .clk(clk), .rst(rst), .c(c), .s(s), .r(r), .ld(ld), .d(d), .clr_cnt(clr_cnt),
      .q(q_o[2]), .qn(qn_o[2]), .chg(chg_o[2]), .sticky(st_o[2]), .conflict(conf_o[2]), .cnt(cnt8[2]));
   sr_latch_bank #(.WIDTH(8), .MODE(3), .RESET_VALUE(8'h00), .CNT_W(8)) u_m3 (
      .clk(clk), .rst(rst), .c(c), .s(s), .r(r), .ld(ld), .d(d), .clr_cnt(clr_cnt),
      .q(q_o[3]), .qn(qn_o[3]), .chg(chg_o[3]), .sticky(st_o[3]), .conflict(conf_o[3]), .cnt(cnt8[3]));
   sr_latch_bank #(.WIDTH(8), .MODE(2), .RESET_VALUE(8'h5A), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .c(c), .s(s), .r(r), .ld(ld), .d(d), .clr_cnt(clr_cnt),
      .q(q_o[4]), .qn(qn_o[4]), .chg(chg_o[4]), .sticky(st_o[4]), .conflict(conf_o[4]), .cnt(cnt2));

   // Bit-by-bit rule table: load, then enable-gated set/reset, then MODE on s&r.
   function automatic logic [7:0] model_next(int mode, logic [7:0] cur);
      logic [7:0] n;
      for (int b = 0; b < 8; b++) begin
         n[b] = cur[b];
         if (ld) n[b] = d[b];
         else if (c) begin
            if (s[b] && !r[b]) n[b] = 1'b1;
            else if (!s[b] && r[b]) n[b] = 1'b0;
            else if (s[b] && r[b]) begin
               if (mode == 0) n[b] = 1'b0;
               else if (mode == 1) n[b] = 1'b1;
               else if (mode == 2) n[b] = ~cur[b];
            end
         end
      end
      return n;
   endfunction

   task automatic tick();
      logic [7:0] nq [NI];
      int         nchanged;
      for (int i = 0; i < NI; i++) nq[i] = model_next(MODES[i], mq[i]);
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            mq[i] = RV[i]; mchg[i] = 8'h00; mst[i] = 8'h00; mconf[i] = 1'b0; mcnt[i] = 0;
         end else begin
            mchg[i]  = nq[i] ^ mq[i];
            nchanged = (mchg[i] != 8'h00) ? 1 : 0;
            mconf[i] = !ld && c && ((s & r) != 8'h00);
            mst[i]   = clr_cnt ? mchg[i] : (mst[i] | mchg[i]);
            if (clr_cnt) mcnt[i] = nchanged;
            else if (nchanged == 1 && mcnt[i] < CMAX[i]) mcnt[i] = mcnt[i] + 1;
            mq[i] = nq[i];
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; c = 1'b0; ld = 1'b0; clr_cnt = 1'b0; s = 8'h00; r = 8'h00; d = 8'h00;
      tick(); tick();
      for (int i = 0; i < NI; i++) begin
         nvec++;
         if (q_o[i] !== RV[i] || cnt_all[i] !== 8'h00 || chg_o[i] !== 8'h00 ||
             st_o[i] !== 8'h00 || conf_o[i] !== 1'b0 || qn_o[i] !== ~RV[i]) begin
            nerr++;
            $display("FAIL reset inst%0d: q=%h qn=%h chg=%h sticky=%h conf=%b cnt=%0d required q=%h cnt=0",
                     i, q_o[i], qn_o[i], chg_o[i], st_o[i], conf_o[i], cnt_all[i], RV[i]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_set_reset();
      c = 1'b1; s = 8'h05; r = 8'h00;
      tick();
      nvec++;
      if (q_o[0] !== 8'h05 || chg_o[0] !== 8'h05 || cnt_all[0] !== 8'd1) begin
         nerr++;
         $display("FAIL set: q=%h chg=%h cnt=%0d required q=05 chg=05 cnt=1", q_o[0], chg_o[0], cnt_all[0]);
      end
      s = 8'h00; r = 8'h01;
      tick();
      nvec++;
      if (q_o[0] !== 8'h04 || chg_o[0] !== 8'h01 || cnt_all[0] !== 8'd2) begin
         nerr++;
         $display("FAIL reset_bit: q=%h chg=%h cnt=%0d required q=04 chg=01 cnt=2", q_o[0], chg_o[0], cnt_all[0]);
      end
   endtask

   task automatic test_enable_gating();
      c = 1'b0; s = 8'hFF; r = 8'h00;
      for (int k = 0; k < 3; k++) begin
         tick();
         nvec++;
         if (q_o[0] !== 8'h04 || chg_o[0] !== 8'h00 || cnt_all[0] !== 8'd2 || conf_o[0] !== 1'b0) begin
            nerr++;
            $display("FAIL gating cyc%0d: q=%h chg=%h cnt=%0d conf=%b required q=04 chg=00 cnt=2 conf=0",
                     k, q_o[0], chg_o[0], cnt_all[0], conf_o[0]);
         end
      end
   endtask

   task automatic test_conflict_modes();
      logic [7:0] want [NI] = '{8'h00, 8'hFF, 8'hF0, 8'h0F, 8'hF0};
      c = 1'b0; ld = 1'b1; d = 8'h0F; s = 8'h00; r = 8'h00;
      tick();
      ld = 1'b0; c = 1'b1; s = 8'hFF; r = 8'hFF;
      tick();
      for (int i = 0; i < NI; i++) begin
         nvec++;
         if (q_o[i] !== want[i] || conf_o[i] !== 1'b1) begin
            nerr++;
            $display("FAIL conflict_mode inst%0d: q=%h conf=%b required q=%h conf=1", i, q_o[i], conf_o[i], want[i]);
         end
      end
      c = 1'b0; s = 8'h00; r = 8'h00;
      tick();
      nvec++;
      if (conf_o[3] !== 1'b0) begin
         nerr++;
         $display("FAIL conflict_pulse: conf=%b required 0", conf_o[3]);
      end
   endtask

   task automatic test_load_priority();
      ld = 1'b1; d = 8'hA5; c = 1'b1; s = 8'hFF; r = 8'h00;
      tick();
      for (int i = 0; i < NI; i++) begin
         nvec++;
         if (q_o[i] !== 8'hA5) begin
            nerr++;
            $display("FAIL load inst%0d: q=%h required A5", i, q_o[i]);
         end
      end
      rst = 1'b1; d = 8'h3C;
      tick();
      for (int i = 0; i < NI; i++) begin
         nvec++;
         if (q_o[i] !== RV[i] || cnt_all[i] !== 8'h00) begin
            nerr++;
            $display("FAIL rst_over_ld inst%0d: q=%h cnt=%0d required q=%h cnt=0", i, q_o[i], cnt_all[i], RV[i]);
         end
      end
      rst = 1'b0; ld = 1'b0; c = 1'b0; s = 8'h00;
   endtask

   task automatic test_saturation();
      int want [6] = '{1, 2, 3, 3, 3, 3};
      c = 1'b1; s = 8'h01; r = 8'h01;
      for (int k = 0; k < 6; k++) begin
         tick();
         nvec++;
         if (cnt_all[4] !== 8'(want[k]) || chg_o[4] !== 8'h01) begin
            nerr++;
            $display("FAIL saturate cyc%0d: cnt=%0d chg=%h required cnt=%0d chg=01", k, cnt_all[4], chg_o[4], want[k]);
         end
      end
      clr_cnt = 1'b1;
      tick();
      nvec++;
      if (cnt_all[4] !== 8'd1 || st_o[4] !== 8'h01) begin
         nerr++;
         $display("FAIL clr_with_change: cnt=%0d sticky=%h required cnt=1 sticky=01", cnt_all[4], st_o[4]);
      end
      clr_cnt = 1'b0; c = 1'b0; s = 8'h00; r = 8'h00;
   endtask

   task automatic test_sticky();
      rst = 1'b1;
      tick();
      rst = 1'b0; c = 1'b1; s = 8'h01; r = 8'h00;
      tick();
      s = 8'h80;
      tick();
      c = 1'b0; s = 8'h00;
      tick();
      nvec++;
      if (st_o[0] !== 8'h81 || cnt_all[0] !== 8'd2 || chg_o[0] !== 8'h00) begin
         nerr++;
         $display("FAIL sticky_accum: sticky=%h cnt=%0d chg=%h required sticky=81 cnt=2 chg=00",
                  st_o[0], cnt_all[0], chg_o[0]);
      end
      clr_cnt = 1'b1;
      tick();
      nvec++;
      if (st_o[0] !== 8'h00 || cnt_all[0] !== 8'd0) begin
         nerr++;
         $display("FAIL clr_no_change: sticky=%h cnt=%0d required sticky=00 cnt=0", st_o[0], cnt_all[0]);
      end
      clr_cnt = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         rst     = ($urandom_range(0, 49) == 0);
         ld      = ($urandom_range(0, 7) == 0);
         clr_cnt = ($urandom_range(0, 9) == 0);
         c       = ($urandom_range(0, 3) != 0);
         s       = 8'($urandom);
         r       = 8'($urandom) & 8'($urandom);
         d       = 8'($urandom);
         tick();
         for (int i = 0; i < NI; i++) begin
            nvec++;
            if (q_o[i] !== mq[i] || qn_o[i] !== ~mq[i] || chg_o[i] !== mchg[i] || st_o[i] !== mst[i] ||
                conf_o[i] !== mconf[i] || cnt_all[i] !== 8'(mcnt[i])) begin
               nerr++;
               $display("FAIL random cyc%0d inst%0d: q=%h qn=%h chg=%h sticky=%h conf=%b cnt=%0d required q=%h chg=%h sticky=%h conf=%b cnt=%0d",
                        k, i, q_o[i], qn_o[i], chg_o[i], st_o[i], conf_o[i], cnt_all[i],
                        mq[i], mchg[i], mst[i], mconf[i], mcnt[i]);
            end
         end
      end
      rst = 1'b0; ld = 1'b0; clr_cnt = 1'b0; c = 1'b0;
   endtask

   initial begin
      test_reset();
      test_set_reset();
      test_enable_gating();
      test_conflict_modes();
      test_load_priority();
      test_saturation();
      test_sticky();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire
